// File: rtl/cpu_pkg.sv
// cpu_pkg: shared arbiter state encoding and grant constants
package cpu_pkg;
  typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY, DONE} arb_state_t;
  localparam logic GRANT_IF = 1'b0;
  localparam logic GRANT_DM = 1'b1;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: fixed-priority IF/MEM arbiter for a single-port memory with IF starvation guard
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  output logic              if_stall_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ack_o,
  output logic              dm_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);
  arb_state_t state;
  logic grant;
  logic [CW-1:0] starve_cnt;
  logic dm_win;
  assign dm_win     = dm_req_i && (starve_cnt < SMAX);
  assign if_stall_o = if_req_i & ~if_ack_o;
  assign dm_stall_o = dm_req_i & ~dm_ack_o;
  // arbitration FSM with registered memory port, completion data and starvation counter
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      grant       <= GRANT_IF;
      starve_cnt  <= '0;
      if_rdata_o  <= '0;
      if_ack_o    <= 1'b0;
      dm_rdata_o  <= '0;
      dm_ack_o    <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dm_win) begin
            grant       <= GRANT_DM;
            mem_req_o   <= 1'b1;
            mem_we_o    <= dm_we_i;
            mem_addr_o  <= dm_addr_i;
            mem_wdata_o <= dm_wdata_i;
            starve_cnt  <= if_req_i ? starve_cnt + 1'b1 : '0;
            state       <= DM_BUSY;
          end else if (if_req_i) begin
            grant       <= GRANT_IF;
            mem_req_o   <= 1'b1;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= if_addr_i;
            mem_wdata_o <= '0;
            starve_cnt  <= '0;
            state       <= IF_BUSY;
          end
        end
        IF_BUSY, DM_BUSY: begin
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            state     <= DONE;
            if (grant == GRANT_DM) begin
              dm_rdata_o <= mem_rdata_i;
              dm_ack_o   <= 1'b1;
            end else begin
              if_rdata_o <= mem_rdata_i;
              if_ack_o   <= 1'b1;
            end
          end
        end
        default: begin
          if_ack_o <= 1'b0;
          dm_ack_o <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule
